// File: rtl/ball_game_gen_if.sv
// Pixel bus between the VGA timing controller (master) and the ball game pixel source (slave).
// No valid/ready handshake: coordinates and vga_vs are valid every cycle; vga_data answers them in the same cycle.
interface ball_game_gen_if;
    logic [9:0] vga_xide;
    logic [9:0] vga_yide;
    logic       vga_vs;
    logic [7:0] vga_data;

    modport master (output vga_xide, output vga_yide, output vga_vs, input vga_data);
    modport slave  (input vga_xide, input vga_yide, input vga_vs, output vga_data);
endinterface

// File: rtl/ball_game_gen.sv
// Ball-and-paddle pixel source: per-frame object update on the end of vsync, combinational RGB332 render.
// Optional macro BALL_GAME_SPEEDUP_EN: ball step grows by 1 every 8th paddle hit, capped at 2*BALL_STEP.
module ball_game_gen #(
    parameter int BALL_SIZE   = 16,
    parameter int BALL_STEP   = 4,
    parameter int PAD_W       = 96,
    parameter int PAD_H       = 12,
    parameter int PAD_Y       = 570,
    parameter int PAD_STEP    = 8,
    parameter int MISS_FRAMES = 60
) (
    input  logic              clk_40mhz,
    input  logic              rst_n,
    ball_game_gen_if.slave    vga,
    input  logic              key_left,
    input  logic              key_right,
    output logic [7:0]        score,
    output logic [1:0]        game_state
);

    localparam logic [1:0] ST_SERVE = 2'd0;
    localparam logic [1:0] ST_PLAY  = 2'd1;
    localparam logic [1:0] ST_MISS  = 2'd2;

    localparam logic [10:0] SCR_W   = 11'd800;
    localparam logic [10:0] SCR_H   = 11'd600;
    localparam logic [10:0] BSZ     = 11'(BALL_SIZE);
    localparam logic [10:0] BSTEP   = 11'(BALL_STEP);
    localparam logic [10:0] PW      = 11'(PAD_W);
    localparam logic [10:0] PH      = 11'(PAD_H);
    localparam logic [10:0] PY      = 11'(PAD_Y);
    localparam logic [10:0] PSTEP   = 11'(PAD_STEP);
    localparam logic [10:0] BX_MAX  = SCR_W - BSZ;
    localparam logic [10:0] PAD_MAX = SCR_W - PW;
    localparam logic [10:0] BX0     = (SCR_W - BSZ) >> 1;
    localparam logic [10:0] BY0     = 11'd100;
    localparam logic [10:0] PAD0    = (SCR_W - PW) >> 1;
    localparam logic [7:0]  MISS_LOAD = 8'(MISS_FRAMES - 1);

    logic        kl_s1_q, kl_s2_q, kr_s1_q, kr_s2_q;
    logic        vs_q;
    logic [1:0]  state_q, state_d;
    logic [10:0] bx_q, bx_d, by_q, by_d;
    logic        dx_q, dx_d, dy_q, dy_d;
    logic [9:0]  pad_q, pad_d;
    logic [7:0]  score_q, score_d;
    logic [7:0]  miss_cnt_q, miss_cnt_d;

    logic        tick;
    logic [10:0] step;
    logic [10:0] pad11;
    logic [10:0] bx_nxt;
    logic        dx_nxt;
    logic        hit_row, hit_col;

`ifdef BALL_GAME_SPEEDUP_EN
    localparam logic [10:0] STEP_MAX = 11'(2 * BALL_STEP);
    logic [10:0] step_q, step_d;
    assign step = step_q;
`else
    assign step = BSTEP;
`endif

    // Frame tick fires on the cycle where vsync has just returned high.
    assign tick  = ~vs_q & vga.vga_vs;
    assign pad11 = {1'b0, pad_q};

    always_comb begin
        bx_nxt = bx_q;
        dx_nxt = dx_q;
        if (dx_q) begin
            bx_nxt = bx_q + step;
            if (bx_nxt > BX_MAX) begin
                bx_nxt = BX_MAX;
                dx_nxt = 1'b0;
            end
        end else if (bx_q < step) begin
            bx_nxt = 11'd0;
            dx_nxt = 1'b1;
        end else begin
            bx_nxt = bx_q - step;
        end
    end

    // Vertical window uses pre-tick by; horizontal overlap uses post-tick bx against pre-tick paddle.
    assign hit_row = (by_q + BSZ <= PY) && (by_q + step + BSZ >= PY);
    assign hit_col = (bx_nxt + BSZ > pad11) && (bx_nxt < pad11 + PW);

    always_comb begin
        state_d    = state_q;
        bx_d       = bx_q;
        by_d       = by_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        pad_d      = pad_q;
        score_d    = score_q;
        miss_cnt_d = miss_cnt_q;
`ifdef BALL_GAME_SPEEDUP_EN
        step_d     = step_q;
`endif
        if (tick && state_q != ST_MISS) begin
            if (kl_s2_q && !kr_s2_q) begin
                pad_d = (pad11 < PSTEP) ? 10'd0 : pad_q - PSTEP[9:0];
            end else if (kr_s2_q && !kl_s2_q) begin
                pad_d = (pad11 + PSTEP > PAD_MAX) ? PAD_MAX[9:0] : pad_q + PSTEP[9:0];
            end
        end
        if (tick) begin
            case (state_q)
                ST_SERVE: begin
                    bx_d = BX0;
                    by_d = BY0;
                    dx_d = 1'b1;
                    dy_d = 1'b1;
                    if (kl_s2_q || kr_s2_q) state_d = ST_PLAY;
                end
                ST_PLAY: begin
                    bx_d = bx_nxt;
                    dx_d = dx_nxt;
                    if (!dy_q) begin
                        if (by_q < step) begin
                            by_d = 11'd0;
                            dy_d = 1'b1;
                        end else begin
                            by_d = by_q - step;
                        end
                    end else if (hit_row && hit_col) begin
                        by_d = PY - BSZ;
                        dy_d = 1'b0;
                        if (score_q != 8'hFF) score_d = score_q + 8'd1;
`ifdef BALL_GAME_SPEEDUP_EN
                        if (score_q != 8'hFF && score_d[2:0] == 3'd0 && step_q < STEP_MAX)
                            step_d = step_q + 11'd1;
`endif
                    end else if (by_q + step + BSZ >= SCR_H) begin
                        // The whole ball stays at its pre-tick position once it is lost.
                        state_d    = ST_MISS;
                        miss_cnt_d = MISS_LOAD;
                        bx_d       = bx_q;
                        dx_d       = dx_q;
                    end else begin
                        by_d = by_q + step;
                    end
                end
                ST_MISS: begin
                    if (miss_cnt_q == 8'd0) begin
                        state_d = ST_SERVE;
                        score_d = 8'd0;
                        bx_d    = BX0;
                        by_d    = BY0;
                        dx_d    = 1'b1;
                        dy_d    = 1'b1;
`ifdef BALL_GAME_SPEEDUP_EN
                        step_d  = BSTEP;
`endif
                    end else begin
                        miss_cnt_d = miss_cnt_q - 8'd1;
                    end
                end
                default: state_d = ST_SERVE;
            endcase
        end
    end

    always_ff @(posedge clk_40mhz or negedge rst_n) begin
        if (!rst_n) begin
            kl_s1_q    <= 1'b0;
            kl_s2_q    <= 1'b0;
            kr_s1_q    <= 1'b0;
            kr_s2_q    <= 1'b0;
            vs_q       <= 1'b0;
            state_q    <= ST_SERVE;
            bx_q       <= BX0;
            by_q       <= BY0;
            dx_q       <= 1'b1;
            dy_q       <= 1'b1;
            pad_q      <= PAD0[9:0];
            score_q    <= 8'd0;
            miss_cnt_q <= 8'd0;
        end else begin
            kl_s1_q    <= key_left;
            kl_s2_q    <= kl_s1_q;
            kr_s1_q    <= key_right;
            kr_s2_q    <= kr_s1_q;
            vs_q       <= vga.vga_vs;
            state_q    <= state_d;
            bx_q       <= bx_d;
            by_q       <= by_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            pad_q      <= pad_d;
            score_q    <= score_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

`ifdef BALL_GAME_SPEEDUP_EN
    always_ff @(posedge clk_40mhz or negedge rst_n) begin
        if (!rst_n) step_q <= BSTEP;
        else        step_q <= step_d;
    end
`endif

    logic [10:0] x11, y11;
    logic        in_ball, in_pad, in_border;

    assign x11       = {1'b0, vga.vga_xide};
    assign y11       = {1'b0, vga.vga_yide};
    assign in_ball   = (x11 >= bx_q) && (x11 < bx_q + BSZ) && (y11 >= by_q) && (y11 < by_q + BSZ);
    assign in_pad    = (x11 >= pad11) && (x11 < pad11 + PW) && (y11 >= PY) && (y11 < PY + PH);
    assign in_border = (x11 < 11'd4) || (x11 >= 11'd796) || (y11 < 11'd4) || (y11 >= 11'd596);

    assign vga.vga_data = in_ball                ? 8'hFF :
                          in_pad                 ? 8'h1C :
                          in_border              ? 8'h03 :
                          (state_q == ST_MISS)   ? 8'hE0 : 8'h00;

    assign score      = score_q;
    assign game_state = state_q;

endmodule

// File: tb/tb_ball_game_gen.sv
// Directed-plus-random bench for ball_game_gen with compressed frames and a behavioural game model.
module tb_ball_game_gen;
    logic       clk_40mhz = 1'b0;
    logic       rst_n;
    logic       key_left, key_right;
    logic [7:0] score;
    logic [1:0] game_state;

    ball_game_gen_if vif();

    ball_game_gen dut (
        .clk_40mhz  (clk_40mhz),
        .rst_n      (rst_n),
        .vga        (vif),
        .key_left   (key_left),
        .key_right  (key_right),
        .score      (score),
        .game_state (game_state)
    );

    always #5 clk_40mhz = ~clk_40mhz;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    logic [9:0] exp_q[$];

    // Game model in screen coordinates.
    int m_bx, m_by, m_dx, m_dy, m_pad, m_score, m_state, m_cnt, m_step;
    bit wall_seen, hit_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_bx = 392; m_by = 100; m_dx = 1; m_dy = 1;
        m_pad = 352; m_score = 0; m_state = 0; m_cnt = 0; m_step = 4;
    endtask

    task automatic model_tick(input bit kl, input bit kr);
        int old_pad, nx, ndx;
        old_pad = m_pad;
        if (m_state != 2) begin
            if (kl && !kr)      m_pad = (m_pad - 8 < 0)   ? 0   : m_pad - 8;
            else if (kr && !kl) m_pad = (m_pad + 8 > 704) ? 704 : m_pad + 8;
        end
        case (m_state)
            0: if (kl || kr) m_state = 1;
            1: begin
                nx  = m_dx ? m_bx + m_step : m_bx - m_step;
                ndx = m_dx;
                if (!m_dx && m_bx < m_step) begin nx = 0; ndx = 1; end
                else if (nx > 784) begin nx = 784; ndx = 0; end
                if (!m_dy) begin
                    if (m_by < m_step) begin m_by = 0; m_dy = 1; end
                    else m_by = m_by - m_step;
                    if (!m_dx && ndx) wall_seen = 1;
                    m_bx = nx; m_dx = ndx;
                end else if (m_by + 16 <= 570 && m_by + m_step + 16 >= 570 &&
                             nx + 16 > old_pad && nx < old_pad + 96) begin
                    m_by = 554; m_dy = 0;
                    if (m_score < 255) m_score++;
`ifdef BALL_GAME_SPEEDUP_EN
                    if (m_score % 8 == 0 && m_step < 8) m_step++;
`endif
                    hit_seen = 1;
                    if (!m_dx && ndx) wall_seen = 1;
                    m_bx = nx; m_dx = ndx;
                end else if (m_by + m_step + 16 >= 600) begin
                    m_state = 2; m_cnt = 59;
                end else begin
                    m_by = m_by + m_step;
                    if (!m_dx && ndx) wall_seen = 1;
                    m_bx = nx; m_dx = ndx;
                end
            end
            default: begin
                if (m_cnt == 0) begin
                    m_state = 0; m_score = 0;
                    m_bx = 392; m_by = 100; m_dx = 1; m_dy = 1; m_step = 4;
                end else m_cnt--;
            end
        endcase
    endtask

    task automatic pix(input int x, input int y, output logic [7:0] d);
        vif.vga_xide = x[9:0];
        vif.vga_yide = y[9:0];
        #1;
        d = vif.vga_data;
    endtask

    // One compressed frame: short vsync pulse, tick on the first edge after it rises.
    task automatic frame(input bit kl, input bit kr);
        key_left  = kl;
        key_right = kr;
        @(negedge clk_40mhz);
        vif.vga_vs = 1'b0;
        repeat (2) @(negedge clk_40mhz);
        vif.vga_vs = 1'b1;
        repeat (2) @(negedge clk_40mhz);
        model_tick(kl, kr);
        exp_q.push_back({m_state[1:0], m_score[7:0]});
    endtask

    task automatic check_ball();
        logic [7:0] d;
        logic [5:0] r;
        r = '0;
        pix(m_bx, m_by, d);           r[0] = (d === 8'hFF);
        pix(m_bx + 15, m_by + 15, d); r[1] = (d === 8'hFF);
        if (m_bx > 0) begin pix(m_bx - 1, m_by, d); r[2] = (d === 8'hFF); end
        if (m_by > 0) begin pix(m_bx, m_by - 1, d); r[3] = (d === 8'hFF); end
        pix(m_bx + 16, m_by + 15, d); r[4] = (d === 8'hFF);
        pix(m_bx + 15, m_by + 16, d); r[5] = (d === 8'hFF);
        check("ball_pos", r, 6'b000011);
    endtask

    task automatic check_pad();
        logic [7:0] d;
        logic [3:0] r;
        if (m_by <= 575 && m_by + 15 >= 575) return;
        r = '0;
        pix(m_pad, 575, d);      r[0] = (d === 8'h1C);
        pix(m_pad + 95, 575, d); r[1] = (d === 8'h1C);
        if (m_pad > 0) begin pix(m_pad - 1, 575, d); r[2] = (d === 8'h1C); end
        pix(m_pad + 96, 575, d); r[3] = (d === 8'h1C);
        check("pad_pos", r, 4'b0011);
    endtask

    task automatic check_frame();
        logic [9:0] e;
        e = exp_q.pop_front();
        check("state_score", {game_state, score}, e);
        check_ball();
        check_pad();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        bit kl, kr, hit_checked;
        int tgt, n;
        rst_n = 1'b0; key_left = 1'b0; key_right = 1'b0;
        vif.vga_vs = 1'b0; vif.vga_xide = '0; vif.vga_yide = '0;
        wall_seen = 0; hit_seen = 0; hit_checked = 0;
        model_reset();
        repeat (3) @(negedge clk_40mhz);

        // Reset state and render while held in reset
        check("rst_state", game_state, 2'd0);
        check("rst_score", score, 8'd0);
        pix(400, 300, d); check("rst_bg", d, 8'h00);
        pix(400, 108, d); check("rst_ball_px", d, 8'hFF);
        pix(360, 575, d); check("rst_pad_px", d, 8'h1C);
        pix(0, 300, d);   check("rst_border_px", d, 8'h03);
        pix(100, 300, d); check("rst_bg2", d, 8'h00);
        rst_n = 1'b1;
        @(negedge clk_40mhz);

        repeat (3) begin frame(0, 0); check_frame(); end

        // A key pulse that dies before the next tick must be ignored
        key_left = 1'b1;
        repeat (3) @(negedge clk_40mhz);
        key_left = 1'b0;
        repeat (4) @(negedge clk_40mhz);
        frame(0, 0); check_frame();

        frame(1, 0); check_frame();
        frame(0, 0); check_frame();
        pix(396, 104, d); check("first_move_in", d, 8'hFF);
        pix(396, 103, d); check("first_move_above", d === 8'hFF, 1'b0);

        // Steer the paddle under the ball until a paddle hit and a left-wall bounce
        n = 0;
        while (!(hit_seen && wall_seen) && m_state == 1 && n < 900) begin
            tgt = m_bx + 8 - 48;
            kl = (m_pad > tgt + 4);
            kr = (m_pad < tgt - 4);
            frame(kl, kr); check_frame();
            if (hit_seen && !hit_checked) begin
                hit_checked = 1;
                check("first_hit_score", score, 8'd1);
                pix(m_bx, 554, d); check("hit_clamp_px", d, 8'hFF);
                pix(m_bx, 553, d); check("hit_clamp_above", d === 8'hFF, 1'b0);
            end
            n++;
        end
        check("steer_reached_hit_and_wall", {hit_seen, wall_seen}, 2'b11);
        pix(m_bx, m_by, d);

        // Random key patterns
        repeat (30) begin
            kl = 1'($urandom_range(0, 1));
            kr = 1'($urandom_range(0, 1));
            frame(kl, kr); check_frame();
        end

        // Get back to a live ball, then keep the paddle on the far side until a miss
        n = 0;
        while (m_state == 2 && n < 100) begin frame(0, 0); check_frame(); n++; end
        n = 0;
        while (m_state != 2 && n < 1500) begin
            if (m_state == 0) begin kl = 1; kr = 0; end
            else begin kl = (m_bx >= 392); kr = (m_bx < 392); end
            frame(kl, kr); check_frame();
            n++;
        end
        check("miss_state", game_state, 2'd2);
        pix(100, 300, d); check("miss_bg", d, 8'hE0);
        repeat (59) begin frame(0, 0); check_frame(); end
        check("miss_hold_59", game_state, 2'd2);
        frame(0, 0); check_frame();
        check("miss_exit_state", game_state, 2'd0);
        check("miss_exit_score", score, 8'd0);

        // Paddle clamps at the right edge, then both keys hold it
        repeat (50) begin frame(0, 1); check_frame(); end
        pix(704, 575, d); check("clamp_left_edge", d, 8'h1C);
        pix(799, 575, d); check("clamp_right_edge", d, 8'h1C);
        pix(703, 575, d); check("clamp_outside", d === 8'h1C, 1'b0);
        n = 0;
        while (m_by != 300 && n < 10) begin frame(1, 1); check_frame(); n++; end
        pix(704, 575, d); check("both_keys_hold", d, 8'h1C);
        check("play_before_reset", game_state, 2'd1);

        // Asynchronous reset mid-frame
        @(negedge clk_40mhz);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_state", game_state, 2'd0);
        check("async_rst_score", score, 8'd0);
        pix(400, 108, d); check("async_rst_ball", d, 8'hFF);
        pix(360, 575, d); check("async_rst_pad", d, 8'h1C);
        pix(704, 575, d); check("async_rst_old_pad", d === 8'h1C, 1'b0);
        vif.vga_vs = 1'b0; key_left = 1'b0; key_right = 1'b0;
        repeat (2) @(negedge clk_40mhz);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk_40mhz);
        frame(0, 0); check_frame();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
